// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the instruction fetch stage:
//     - DEFAULT_RESET_PC : boot vector used as the RESET_PC parameter default
//     - br_type_e        : branch condition codes driven by decode on de_b_type
//     - fetch_state_e    : fetch FSM state encodings (RST / BOOT / RUN)
//     - branch_offset()  : sign-extended, word-scaled branch displacement
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    // Branch condition codes. Any code other than BEQ compares for inequality.
    typedef enum logic [3:0] {
        BR_BNE = 4'b0000,
        BR_BEQ = 4'b0001
    } br_type_e;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } fetch_state_e;

    // 16-bit immediate -> signed byte displacement (word offset << 2).
    function automatic logic [31:0] branch_offset(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage : fetch_stage_pkg

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
//   Purely combinational branch/jump resolution for the instruction that decode
//   currently holds (whose address is fe_pc).
//
//   Ports:
//     fe_pc        in  32  address of the instruction in decode
//     de_is_b      in   1  instruction is BEQ/BNE
//     de_is_j      in   1  instruction is J/JAL
//     de_is_jr     in   1  instruction is JR
//     de_b_type    in   4  branch condition code (BEQ compares equal, else not-equal)
//     de_b_offset  in  16  branch immediate (word offset)
//     de_j_index   in  26  jump index
//     de_rs_data   in  32  forwarded rs value
//     de_rt_data   in  32  forwarded rt value
//     taken        out  1  control transfer will happen
//     target       out 32  destination address (meaningful only when taken)
// -----------------------------------------------------------------------------
module fetch_next_pc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] fe_pc,
    input  logic        de_is_b,
    input  logic        de_is_j,
    input  logic        de_is_jr,
    input  logic [3:0]  de_b_type,
    input  logic [15:0] de_b_offset,
    input  logic [25:0] de_j_index,
    input  logic [31:0] de_rs_data,
    input  logic [31:0] de_rt_data,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;
    logic        rs_eq_rt;
    logic        b_cond;

    assign pc_plus4 = fe_pc + 32'd4;
    assign rs_eq_rt = (de_rs_data == de_rt_data);
    assign b_cond   = (de_b_type == BR_BEQ) ? rs_eq_rt : !rs_eq_rt;
    assign taken    = de_is_j | de_is_jr | (de_is_b & b_cond);

    // J/JR/B are mutually exclusive from decode; the ordering below only
    // fixes a deterministic target should more than one ever be asserted.
    always_comb begin
        target = pc_plus4 + branch_offset(de_b_offset);
        if (de_is_j) begin
            target = {pc_plus4[31:28], de_j_index, 2'b00};
        end else if (de_is_jr) begin
            target = de_rs_data;
        end
    end

endmodule : fetch_next_pc

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   First stage of the 5-stage MIPS pipeline. Issues instruction-SRAM reads,
//   tags the returned data with its address for decode, redirects the PC one
//   instruction after a taken branch/jump (architectural delay slot) and
//   replays the held instruction while decode stalls.
//
//   Parameters:
//     RESET_PC         first instruction address after reset
//
//   Ports:
//     clk              in   1  clock
//     resetn           in   1  synchronous active-low reset
//     inst_sram_en     out  1  SRAM read enable
//     inst_sram_addr   out 32  read address (data returns next cycle)
//     inst_sram_rdata  in  32  data for the address issued last cycle
//     de_stall         in   1  decode holds its instruction this cycle
//     de_is_b/j/jr     in   1  decode instruction class
//     de_b_type        in   4  branch condition code
//     de_b_offset      in  16  branch immediate
//     de_j_index       in  26  jump index
//     de_rs_data       in  32  forwarded rs value
//     de_rt_data       in  32  forwarded rt value
//     fe_inst          out 32  instruction to decode (0 when !fe_valid)
//     fe_pc            out 32  address of fe_inst
//     fe_valid         out  1  fe_inst is a real instruction
//     fe_redirect      out  1  this cycle's issue address is a branch target
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        de_stall,
    input  logic        de_is_b,
    input  logic        de_is_j,
    input  logic        de_is_jr,
    input  logic [3:0]  de_b_type,
    input  logic [15:0] de_b_offset,
    input  logic [25:0] de_j_index,
    input  logic [31:0] de_rs_data,
    input  logic [31:0] de_rt_data,
    output logic [31:0] fe_inst,
    output logic [31:0] fe_pc,
    output logic        fe_valid,
    output logic        fe_redirect
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fe_pc_q, fe_pc_d;
    logic         fe_valid_q, fe_valid_d;
    logic         br_pend_q, br_pend_d;
    logic [31:0]  br_target_q, br_target_d;

    logic         issue_en;
    logic [31:0]  issue_addr;
    logic         issue_redirect;

    logic         np_taken;
    logic [31:0]  np_target;

    fetch_next_pc u_next_pc (
        .fe_pc       (fe_pc_q),
        .de_is_b     (de_is_b),
        .de_is_j     (de_is_j),
        .de_is_jr    (de_is_jr),
        .de_b_type   (de_b_type),
        .de_b_offset (de_b_offset),
        .de_j_index  (de_j_index),
        .de_rs_data  (de_rs_data),
        .de_rt_data  (de_rt_data),
        .taken       (np_taken),
        .target      (np_target)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        fe_pc_d        = fe_pc_q;
        fe_valid_d     = fe_valid_q;
        br_pend_d      = br_pend_q;
        br_target_d    = br_target_q;
        issue_en       = 1'b0;
        issue_addr     = RESET_PC;
        issue_redirect = 1'b0;

        unique case (state_q)
            ST_RST: begin
                state_d     = ST_BOOT;
                fe_pc_d     = RESET_PC;
                fe_valid_d  = 1'b0;
                br_pend_d   = 1'b0;
                br_target_d = '0;
            end

            ST_BOOT: begin
                issue_en   = 1'b1;
                issue_addr = RESET_PC;
                fe_pc_d    = RESET_PC;
                fe_valid_d = 1'b1;
                state_d    = ST_RUN;
            end

            ST_RUN: begin
                issue_en = 1'b1;
                if (de_stall) begin
                    // Re-read the held instruction; a pending target waits.
                    issue_addr = fe_pc_q;
                end else if (br_pend_q) begin
                    issue_addr     = br_target_q;
                    issue_redirect = 1'b1;
                    br_pend_d      = 1'b0;
                end else begin
                    issue_addr = fe_pc_q + 32'd4;
                end
                fe_pc_d = issue_addr;

                // The delay slot is already in flight this cycle, so a taken
                // branch only arms br_pend; it issues on a later cycle. Placed
                // after the consume above so a branch in a delay slot re-arms.
                if (fe_valid_q && !de_stall && np_taken) begin
                    br_pend_d   = 1'b1;
                    br_target_d = np_target;
                end
            end

            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_RST;
            fe_pc_q     <= RESET_PC;
            fe_valid_q  <= 1'b0;
            br_pend_q   <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q     <= state_d;
            fe_pc_q     <= fe_pc_d;
            fe_valid_q  <= fe_valid_d;
            br_pend_q   <= br_pend_d;
            br_target_q <= br_target_d;
        end
    end

    // While resetn is low the outputs take their reset values immediately, so
    // a pending target can never be issued in the cycle reset is asserted.
    always_comb begin
        inst_sram_en   = issue_en;
        inst_sram_addr = issue_addr;
        fe_redirect    = issue_redirect;
        fe_pc          = fe_pc_q;
        fe_valid       = fe_valid_q;
        if (!resetn) begin
            inst_sram_en   = 1'b0;
            inst_sram_addr = RESET_PC;
            fe_redirect    = 1'b0;
            fe_pc          = RESET_PC;
            fe_valid       = 1'b0;
        end
    end

    assign fe_inst = fe_valid ? inst_sram_rdata : 32'd0;

endmodule : fetch_stage
